// File: rtl/alu_exec_unit.sv
// Multi-cycle 8-bit ALU execution unit: accept, read operands, optional shift-add
// multiply, then a single write-back cycle that also updates the flags.
module alu_exec_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_opcode,
    input  logic [3:0] instr_rd,
    input  logic [3:0] instr_rs1,
    input  logic [3:0] instr_rs2,
    output logic [3:0] reg1_read_addr,
    output logic [3:0] reg2_read_addr,
    input  logic [7:0] reg1_read_data_in,
    input  logic [7:0] reg2_read_data_in,
    output logic [3:0] reg_write_address_out,
    output logic [7:0] reg_write_data_out,
    output logic       reg_write_enable,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [1:0] {StIdle, StRead, StMul, StWb} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, rd_q, rs1_q, rs2_q;
    logic [7:0]  a_q, b_q;
    logic [15:0] prod_q, mcand_q;
    logic [7:0]  mplier_q;
    logic [2:0]  cnt_q;
    logic        zero_q, carry_q;

    logic [7:0]  res;
    logic        res_carry;
    logic        legal;
    logic [8:0]  sum;

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        res       = 8'h00;
        res_carry = 1'b0;
        legal     = 1'b1;
        case (op_q)
            4'd0: begin
                res       = sum[7:0];
                res_carry = sum[8];
            end
            4'd1: begin
                res       = a_q - b_q;
                res_carry = (a_q < b_q);
            end
            4'd2: res = a_q & b_q;
            4'd3: res = a_q | b_q;
            4'd4: res = a_q ^ b_q;
            4'd5: res = a_q << b_q[2:0];
            4'd6: res = a_q >> b_q[2:0];
            4'd7: begin
                res       = prod_q[7:0];
                res_carry = |prod_q[15:8];
            end
            4'd8: res = a_q;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (instr_valid && instr_ready) state_d = StRead;
            StRead: state_d = (op_q == 4'd7) ? StMul : StWb;
            StMul:  if (cnt_q == 3'd7) state_d = StWb;
            StWb:   state_d = StIdle;
        endcase
    end

    always_comb begin
        instr_ready           = (state_q == StIdle) && !reset;
        reg1_read_addr        = 4'h0;
        reg2_read_addr        = 4'h0;
        reg_write_address_out = 4'h0;
        reg_write_data_out    = 8'h00;
        reg_write_enable      = 1'b0;
        done                  = 1'b0;
        illegal               = 1'b0;
        if (state_q == StRead) begin
            reg1_read_addr = rs1_q;
            reg2_read_addr = rs2_q;
        end
        if (state_q == StWb) begin
            reg_write_address_out = rd_q;
            reg_write_data_out    = res;
            reg_write_enable      = legal;
            done                  = 1'b1;
            illegal               = !legal;
        end
    end

    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= 4'h0;
            rd_q     <= 4'h0;
            rs1_q    <= 4'h0;
            rs2_q    <= 4'h0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            prod_q   <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            cnt_q    <= 3'd0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        op_q  <= instr_opcode;
                        rd_q  <= instr_rd;
                        rs1_q <= instr_rs1;
                        rs2_q <= instr_rs2;
                    end
                end
                StRead: begin
                    a_q      <= reg1_read_data_in;
                    b_q      <= reg2_read_data_in;
                    mcand_q  <= {8'h00, reg1_read_data_in};
                    mplier_q <= reg2_read_data_in;
                    prod_q   <= 16'h0000;
                    cnt_q    <= 3'd0;
                end
                StMul: begin
                    // One multiplier bit per cycle, LSB first.
                    if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 3'd1;
                end
                StWb: begin
                    if (legal) begin
                        zero_q  <= (res == 8'h00);
                        carry_q <= res_carry;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with a behavioural 16x8 register file.
module tb_alu_exec_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_opcode, instr_rd, instr_rs1, instr_rs2;
    logic [3:0] reg1_read_addr, reg2_read_addr;
    logic [7:0] reg1_read_data_in, reg2_read_data_in;
    logic [3:0] reg_write_address_out;
    logic [7:0] reg_write_data_out;
    logic       reg_write_enable;
    logic       flag_zero, flag_carry, done, illegal;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;

    logic [7:0] rf [16];

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .instr_opcode         (instr_opcode),
        .instr_rd             (instr_rd),
        .instr_rs1            (instr_rs1),
        .instr_rs2            (instr_rs2),
        .reg1_read_addr       (reg1_read_addr),
        .reg2_read_addr       (reg2_read_addr),
        .reg1_read_data_in    (reg1_read_data_in),
        .reg2_read_data_in    (reg2_read_data_in),
        .reg_write_address_out(reg_write_address_out),
        .reg_write_data_out   (reg_write_data_out),
        .reg_write_enable     (reg_write_enable),
        .flag_zero            (flag_zero),
        .flag_carry           (flag_carry),
        .done                 (done),
        .illegal              (illegal)
    );

    assign reg1_read_data_in = rf[reg1_read_addr];
    assign reg2_read_data_in = rf[reg2_read_addr];

    // Register file is reloaded with known contents whenever reset is held.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
            rf[1]  <= 8'hF0; rf[2]  <= 8'h20; rf[4]  <= 8'h05; rf[5]  <= 8'h03;
            rf[6]  <= 8'h04; rf[7]  <= 8'h13; rf[8]  <= 8'h11; rf[9]  <= 8'h0F;
            rf[10] <= 8'h03; rf[11] <= 8'h81; rf[12] <= 8'h09; rf[15] <= 8'hAA;
        end else if (reg_write_enable) begin
            rf[reg_write_address_out] <= reg_write_data_out;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic [7:0] exp_data,
                       input logic exp_c, input logic exp_z, input int exp_lat,
                       input logic exp_ill);
        int  n;
        bit  got;
        @(negedge clk);
        check({tag, " ready"}, 16'(instr_ready), 16'd1);
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_rd     = rd;
        instr_rs1    = rs1;
        instr_rs2    = rs2;
        @(posedge clk);
        #1;
        instr_valid  = 1'b0;
        // Scramble the instruction fields; they must be ignored once accepted.
        instr_opcode = 4'hD;
        instr_rd     = 4'h0;
        instr_rs1    = 4'h0;
        instr_rs2    = 4'h0;
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check({tag, " rs1 addr"}, 16'(reg1_read_addr), 16'(rs1));
                check({tag, " rs2 addr"}, 16'(reg2_read_addr), 16'(rs2));
            end
            if (done) got = 1'b1;
        end
        check({tag, " latency"}, 16'(n), 16'(exp_lat));
        if (got) begin
            check({tag, " we"}, 16'(reg_write_enable), 16'(!exp_ill));
            check({tag, " illegal"}, 16'(illegal), 16'(exp_ill));
            if (!exp_ill) begin
                check({tag, " waddr"}, 16'(reg_write_address_out), 16'(rd));
                check({tag, " wdata"}, 16'(reg_write_data_out), 16'(exp_data));
            end
        end
        @(negedge clk);
        check({tag, " carry"}, 16'(flag_carry), 16'(exp_c));
        check({tag, " zero"}, 16'(flag_zero), 16'(exp_z));
        check({tag, " done width"}, 16'(done), 16'd0);
    endtask

    initial begin
        int          wc;
        int          acc;
        bit          saw_done;
        logic [8:0]  rdy_pat, done_pat;

        reset        = 1'b1;
        instr_valid  = 1'b0;
        instr_opcode = 4'h0;
        instr_rd     = 4'h0;
        instr_rs1    = 4'h0;
        instr_rs2    = 4'h0;
        repeat (2) @(negedge clk);
        check("rst ready", 16'(instr_ready), 16'd0);
        check("rst flags", {14'd0, flag_zero, flag_carry}, 16'd0);
        check("rst strobes", {13'd0, reg_write_enable, done, illegal}, 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post rst ready", 16'(instr_ready), 16'd1);

        run("add",   4'd0, 4'd3,  4'd1,  4'd2,  8'h10, 1'b1, 1'b0, 2, 1'b0);
        check("rf3", 16'(rf[3]), 16'h0010);
        run("sub0",  4'd1, 4'd13, 4'd4,  4'd4,  8'h00, 1'b0, 1'b1, 2, 1'b0);
        run("subb",  4'd1, 4'd14, 4'd5,  4'd6,  8'hFF, 1'b1, 1'b0, 2, 1'b0);
        wc = we_cnt;
        run("ill",   4'hC, 4'd13, 4'd1,  4'd2,  8'h00, 1'b1, 1'b0, 2, 1'b1);
        check("ill no write", 16'(we_cnt), 16'(wc));
        check("ill rf13", 16'(rf[13]), 16'h0000);

        // Abort a MUL on its 4th cycle (cycle 5 after acceptance).
        @(negedge clk);
        instr_valid  = 1'b1;
        instr_opcode = 4'd7;
        instr_rd     = 4'd15;
        instr_rs1    = 4'd7;
        instr_rs2    = 4'd8;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        wc    = we_cnt;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort ready", 16'(instr_ready), 16'd1);
        check("abort flags", {14'd0, flag_zero, flag_carry}, 16'd0);
        check("abort strobes", {13'd0, reg_write_enable, done, illegal}, 16'd0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || illegal) saw_done = 1'b1;
        end
        check("abort no done", 16'(saw_done), 16'd0);
        check("abort no write", 16'(we_cnt), 16'(wc));
        check("abort rf15", 16'(rf[15]), 16'h00AA);

        run("mul1",  4'd7, 4'd13, 4'd7,  4'd8,  8'h43, 1'b1, 1'b0, 10, 1'b0);
        run("mul2",  4'd7, 4'd14, 4'd9,  4'd10, 8'h2D, 1'b0, 1'b0, 10, 1'b0);
        run("and",   4'd2, 4'd3,  4'd1,  4'd2,  8'h20, 1'b0, 1'b0, 2, 1'b0);
        run("or",    4'd3, 4'd3,  4'd1,  4'd2,  8'hF0, 1'b0, 1'b0, 2, 1'b0);
        run("xor",   4'd4, 4'd3,  4'd1,  4'd2,  8'hD0, 1'b0, 1'b0, 2, 1'b0);
        run("shr",   4'd6, 4'd3,  4'd11, 4'd12, 8'h40, 1'b0, 1'b0, 2, 1'b0);
        run("mov",   4'd8, 4'd3,  4'd1,  4'd2,  8'hF0, 1'b0, 1'b0, 2, 1'b0);
        run("shl",   4'd5, 4'd15, 4'd11, 4'd12, 8'h02, 1'b0, 1'b0, 2, 1'b0);
        run("rd=rs", 4'd0, 4'd9,  4'd9,  4'd10, 8'h12, 1'b0, 1'b0, 2, 1'b0);
        check("rf9", 16'(rf[9]), 16'h0012);

        // Three ADDs offered back to back with instr_valid held high.
        @(posedge clk);
        #1;
        instr_valid  = 1'b1;
        instr_opcode = 4'd0;
        instr_rd     = 4'd0;
        instr_rs1    = 4'd2;
        instr_rs2    = 4'd2;
        acc          = 0;
        rdy_pat      = 9'd0;
        done_pat     = 9'd0;
        for (int c = 0; c < 9; c++) begin
            bit accepted;
            @(negedge clk);
            rdy_pat[c]  = instr_ready;
            done_pat[c] = done;
            accepted    = instr_ready && instr_valid;
            if (accepted) acc++;
            @(posedge clk);
            #1;
            if (accepted) begin
                if (acc >= 3) instr_valid = 1'b0;
                else instr_rd = (acc == 1) ? 4'd3 : 4'd5;
            end
        end
        @(negedge clk);
        check("b2b ready", 16'(rdy_pat), 16'(9'b001001001));
        check("b2b done", 16'(done_pat), 16'(9'b100100100));
        check("b2b rf", {rf[0], rf[3]}, 16'h4040);
        check("b2b rf5", 16'(rf[5]), 16'h0040);

        // Reset wins over an instruction offered in the same cycle.
        @(negedge clk);
        reset        = 1'b1;
        instr_valid  = 1'b1;
        instr_opcode = 4'd0;
        instr_rs1    = 4'd1;
        instr_rs2    = 4'd2;
        #1 check("prio ready", 16'(instr_ready), 16'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        check("prio idle", 16'(instr_ready), 16'd1);
        check("prio no read", 16'(reg1_read_addr), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 instr_valid  in  1  instruction offered this cycle.
REQ-005 instr_ready  out  1  block accepts an instruction this cycle.
REQ-006 instr_opcode  in  4  operation code.
REQ-007 instr_rd  in  4  destination register index.
REQ-008 instr_rs1, instr_rs2  in  4 each  source register indices.
REQ-009 reg1_read_addr, reg2_read_addr  out  4 each  read addresses to the 16x8 register file.
REQ-010 reg1_read_data_in, reg2_read_data_in  in  8 each  combinational read data returned by the register file in the same cycle.
REQ-011 reg_write_address_out  out  4  write-back register index.
REQ-012 reg_write_data_out  out  8  write-back data.
REQ-013 reg_write_enable  out  1  write-back strobe, one cycle wide.
REQ-014 flag_zero, flag_carry  out  1 each  flags from the last completed operation.
REQ-015 done  out  1  one-cycle pulse when an instruction retires.
REQ-016 illegal  out  1  one-cycle pulse, concurrent with done, when the opcode is unsupported.

Function
REQ-017 The block SHALL implement the states IDLE, READ, MUL and WB.
REQ-018 instr_ready SHALL be 1 only in IDLE, and an instruction is accepted on a clock edge where instr_valid and instr_ready are both 1.
REQ-019 On acceptance, the block SHALL latch opcode, rd, rs1 and rs2, then go IDLE->READ.
REQ-020 In READ, reg1_read_addr and reg2_read_addr SHALL equal the latched rs1 and rs2; in all other states they SHALL be 0.
REQ-021 At the end of READ, the block SHALL capture both operands, A=reg1_read_data_in and B=reg2_read_data_in.
REQ-022 From READ, the next state SHALL be MUL for opcode 7 and WB for every other opcode.
REQ-023 Opcodes: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 SHL A<<B[2:0]; 6 SHR A>>B[2:0] (logical); 7 MUL low byte of A*B; 8 MOV A.
REQ-024 Opcodes 9-15 are illegal.
REQ-025 Arithmetic SHALL be 8-bit unsigned, and the result SHALL be truncated to 8 bits.
REQ-026 Carry SHALL be: ADD bit 8 of the 9-bit sum; SUB 1 when A<B (borrow); MUL 1 when the 16-bit product exceeds 255; 0 for all other opcodes.
REQ-027 MUL SHALL be shift-add, 1 multiplier bit per cycle, exactly 8 cycles in MUL, then WB.
REQ-028 In WB, reg_write_enable SHALL be 1 for legal opcodes and 0 for illegal ones.
REQ-029 In WB, reg_write_address_out SHALL equal the latched rd and reg_write_data_out SHALL equal the result.
REQ-030 In WB, done SHALL pulse and the flags SHALL update; the next state is IDLE.
REQ-031 For an illegal opcode, the block SHALL pulse done and illegal, hold the flags, and write nothing.
REQ-032 Latency from the acceptance edge to the WB cycle SHALL be 2 cycles for non-MUL and 10 cycles for MUL.
REQ-033 Back-to-back throughput SHALL be one instruction per 3 cycles (non-MUL).
REQ-034 rd equal to rs1 or rs2 SHALL be legal; operands are already captured before the write.
REQ-035 Writes to any index 0-15 SHALL be permitted.
REQ-036 flag_zero SHALL be 1 when the 8-bit result is 0.
REQ-037 Outside WB, reg_write_enable, done and illegal SHALL be 0, and reg_write_address_out and reg_write_data_out SHALL be 0.
REQ-038 Changes on the instr_* inputs SHALL be ignored outside IDLE.

Reset
REQ-039 When reset=1 at a clock edge, the state SHALL become IDLE, all latched fields and operands SHALL clear to 0, and flag_zero and flag_carry SHALL clear to 0.
REQ-040 Reset asserted during READ, MUL or WB SHALL abort the instruction with no write, no done, and no illegal pulse in the following cycle.
REQ-041 instr_ready SHALL be 0 in any cycle where reset=1, and 1 in the first cycle after reset deasserts.
REQ-042 Reset SHALL take priority over an instruction offered in the same cycle.

Verification
REQ-043 ADD with R1=0xF0, R2=0x20, rd=3 -> WB 2 cycles after accept; write addr 3, data 0x10, carry=1, zero=0, done pulse.
REQ-044 SUB with A=0x05, B=0x05 -> data 0x00, zero=1, carry=0; SUB with A=0x03, B=0x04 -> data 0xFF, carry=1.
REQ-045 MUL with A=0x13, B=0x11 -> WB exactly 10 cycles after accept, data 0x43, carry=1 (product 0x143); A=0x0F, B=0x03 -> data 0x2D, carry=0.
REQ-046 Opcode 0xC -> done and illegal pulse together, reg_write_enable stays 0, flags unchanged from the prior instruction.
REQ-047 reset asserted on the 4th MUL cycle -> next cycle IDLE, instr_ready=1, flags 0, and no write strobe appears.
REQ-048 instr_valid held high with 3 ADDs queued -> accepts on cycles 0, 3 and 6; instr_ready=0 during READ and WB; SHL A=0x81, B=0x09 -> data 0x02 (shift by 1).
